// File: rtl/vga_mode_ctrl_if.sv
// Mode-change request channel between the system control logic (master)
// and vga_mode_ctrl (slave).
//
// Handshake: a request transfers on every rising clk edge where
// req_valid && req_ready are both high. The master keeps req_valid and
// req_mode stable until that edge. req_ready does not depend on req_valid,
// and the slave may raise or drop it on any cycle.
interface vga_mode_ctrl_if;
   logic       req_valid;
   logic [1:0] req_mode;
   logic       req_ready;

   modport master (
      output req_valid,
      output req_mode,
      input  req_ready
   );

   modport slave (
      input  req_valid,
      input  req_mode,
      output req_ready
   );
endinterface

// File: rtl/vga_mode_ctrl.sv
// vga_mode_ctrl: runtime video-mode controller for the VGA timing chain.
// Holds a four-entry preset table and drives the h/v line-timer
// configuration. A mode change is accepted in RUN, is applied on the next
// frame_end (never on the acceptance cycle), and then holds the timers in
// reset until the pixel PLL has stayed locked for SETTLE_CYCLES cycles.
//
// Optional feature macro: VGA_MODE_CTRL_TIMEOUT_EN
//   defined   : WAIT_FRAME forces the change after TIMEOUT_CYCLES cycles
//               without a frame_end, as if frame_end arrived on that cycle.
//   undefined : WAIT_FRAME waits for frame_end indefinitely.
module vga_mode_ctrl #(
   parameter int         LINE_WIDTH     = 12,
   parameter int         SETTLE_CYCLES  = 16,
   parameter logic [1:0] DEFAULT_MODE   = 2'd0,
   parameter int         TIMEOUT_CYCLES = 2**20
) (
   input  logic                  clk,
   input  logic                  rstn,
   vga_mode_ctrl_if.slave        req,
   input  logic                  pll_locked,
   input  logic                  frame_end,
   output logic                  timers_rstn,
   output logic [LINE_WIDTH-1:0] h_visible,
   output logic [LINE_WIDTH-1:0] h_front,
   output logic [LINE_WIDTH-1:0] h_sync,
   output logic [LINE_WIDTH-1:0] h_back,
   output logic [LINE_WIDTH-1:0] v_visible,
   output logic [LINE_WIDTH-1:0] v_front,
   output logic [LINE_WIDTH-1:0] v_sync,
   output logic [LINE_WIDTH-1:0] v_back,
   output logic                  h_pol,
   output logic                  v_pol,
   output logic [1:0]            cur_mode,
   output logic                  busy,
   output logic                  mode_changed,
   output logic [1:0]            fsm_state
);

   // FSM encoding; fsm_state exposes the raw register for debug
   localparam logic [1:0] ST_HOLD       = 2'd0;
   localparam logic [1:0] ST_RUN        = 2'd1;
   localparam logic [1:0] ST_WAIT_FRAME = 2'd2;

   // settle_cnt only needs to reach SETTLE_CYCLES-1
   localparam int SETTLE_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);

   // One preset entry; 11 bits covers the widest value (1280)
   typedef struct packed {
      logic [10:0] hv;
      logic [10:0] hf;
      logic [10:0] hs;
      logic [10:0] hb;
      logic [10:0] vv;
      logic [10:0] vf;
      logic [10:0] vs;
      logic [10:0] vb;
      logic        hp;
      logic        vp;
   } preset_t;

   // Preset table; polarity 1 = active-high sync
   function automatic preset_t preset(input logic [1:0] m);
      preset_t p;
      case (m)
         2'd0:    p = '{11'd640,  11'd16,  11'd96,  11'd48,
                        11'd480,  11'd10,  11'd2,   11'd33, 1'b0, 1'b0};
         2'd1:    p = '{11'd800,  11'd40,  11'd128, 11'd88,
                        11'd600,  11'd1,   11'd4,   11'd23, 1'b1, 1'b1};
         2'd2:    p = '{11'd1024, 11'd24,  11'd136, 11'd160,
                        11'd768,  11'd3,   11'd6,   11'd29, 1'b0, 1'b0};
         default: p = '{11'd1280, 11'd110, 11'd40,  11'd220,
                        11'd720,  11'd5,   11'd5,   11'd20, 1'b1, 1'b1};
      endcase
      return p;
   endfunction

   logic [1:0]          state;
   logic [1:0]          state_nxt;
   logic [SETTLE_W-1:0] settle_cnt;
   logic [1:0]          pend_mode;
   logic                boot;
   preset_t             cfg;

   logic accept;
   logic accept_change;
   logic settle_done;
   logic timeout_hit;
   logic apply;

   assign accept        = (state == ST_RUN) && req.req_valid;
   assign accept_change = accept && (req.req_mode != cur_mode);
   assign settle_done   = (state == ST_HOLD) && pll_locked && (settle_cnt == SETTLE_LAST);
   // A frame_end (or a forced timeout) only matters while a change is pending
   assign apply         = (state == ST_WAIT_FRAME) && (frame_end || timeout_hit);

`ifdef VGA_MODE_CTRL_TIMEOUT_EN
   localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

   logic [TO_W-1:0] wait_cnt;

   // Count cycles spent in WAIT_FRAME; zero on the first WAIT_FRAME cycle
   always_ff @(posedge clk) begin
      if (!rstn || state != ST_WAIT_FRAME) begin
         wait_cnt <= '0;
      end else if (wait_cnt != TO_LAST) begin
         wait_cnt <= wait_cnt + 1'b1;
      end
   end

   assign timeout_hit = (state == ST_WAIT_FRAME) && (wait_cnt == TO_LAST);
`else
   assign timeout_hit = 1'b0;
`endif

   // Next-state decode
   always_comb begin
      state_nxt = state;
      case (state)
         ST_HOLD:       if (settle_done)   state_nxt = ST_RUN;
         ST_RUN:        if (accept_change) state_nxt = ST_WAIT_FRAME;
         ST_WAIT_FRAME: if (apply)         state_nxt = ST_HOLD;
         default:                          state_nxt = ST_HOLD;
      endcase
   end

   // Settle counter: runs only in HOLD with lock; any lock drop restarts it
   always_ff @(posedge clk) begin
      if (!rstn || state != ST_HOLD || !pll_locked || settle_done) begin
         settle_cnt <= '0;
      end else begin
         settle_cnt <= settle_cnt + 1'b1;
      end
   end

   // State, pending mode, live parameter set and the release pulse
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state        <= ST_HOLD;
         cur_mode     <= DEFAULT_MODE;
         pend_mode    <= DEFAULT_MODE;
         cfg          <= preset(DEFAULT_MODE);
         boot         <= 1'b1;
         mode_changed <= 1'b0;
      end else begin
         state        <= state_nxt;
         // The first release after reset is not a mode change
         mode_changed <= settle_done && !boot;
         if (settle_done) begin
            boot <= 1'b0;
         end
         if (accept_change) begin
            pend_mode <= req.req_mode;
         end
         if (apply) begin
            cur_mode <= pend_mode;
            cfg      <= preset(pend_mode);
         end
      end
   end

   // Status and handshake outputs decoded from the state register
   assign req.req_ready = (state == ST_RUN);
   assign busy          = (state != ST_RUN);
   assign timers_rstn   = (state == ST_RUN) || (state == ST_WAIT_FRAME);
   assign fsm_state     = state;

   // Zero-extend the registered preset onto the timer configuration bus
   assign h_visible = LINE_WIDTH'(cfg.hv);
   assign h_front   = LINE_WIDTH'(cfg.hf);
   assign h_sync    = LINE_WIDTH'(cfg.hs);
   assign h_back    = LINE_WIDTH'(cfg.hb);
   assign v_visible = LINE_WIDTH'(cfg.vv);
   assign v_front   = LINE_WIDTH'(cfg.vf);
   assign v_sync    = LINE_WIDTH'(cfg.vs);
   assign v_back    = LINE_WIDTH'(cfg.vb);
   assign h_pol     = cfg.hp;
   assign v_pol     = cfg.vp;

endmodule

// File: tb/tb_vga_mode_ctrl.sv
// Testbench for vga_mode_ctrl. Random mode-change traffic with directed
// corner cases; expected release events are queued and matched against
// every mode_changed pulse, state/parameter expectations come from the
// mode table and the timing rules of the block.
`timescale 1ns/1ps
module tb_vga_mode_ctrl;
   localparam int LW     = 12;
   localparam int SETTLE = 16;
   localparam int TMO    = 64;
   localparam int EXP_W  = 132;
`ifdef VGA_MODE_CTRL_TIMEOUT_EN
   localparam int MAX_DELAY = 60;
`else
   localparam int MAX_DELAY = 98;
`endif

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rstn;
   logic pll_locked;
   logic frame_end;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- DUT ----------------
   vga_mode_ctrl_if req_if();
   logic          timers_rstn, h_pol, v_pol, busy, mode_changed;
   logic [LW-1:0] h_visible, h_front, h_sync, h_back;
   logic [LW-1:0] v_visible, v_front, v_sync, v_back;
   logic [1:0]    cur_mode, fsm_state;

   vga_mode_ctrl #(
      .LINE_WIDTH(LW), .SETTLE_CYCLES(SETTLE), .DEFAULT_MODE(2'd0), .TIMEOUT_CYCLES(TMO)
   ) dut (
      .clk(clk), .rstn(rstn), .req(req_if.slave),
      .pll_locked(pll_locked), .frame_end(frame_end), .timers_rstn(timers_rstn),
      .h_visible(h_visible), .h_front(h_front), .h_sync(h_sync), .h_back(h_back),
      .v_visible(v_visible), .v_front(v_front), .v_sync(v_sync), .v_back(v_back),
      .h_pol(h_pol), .v_pol(v_pol), .cur_mode(cur_mode), .busy(busy),
      .mode_changed(mode_changed), .fsm_state(fsm_state)
   );

   // ---------------- reference mode table ----------------
   int hv[4] = '{640, 800, 1024, 1280};
   int hf[4] = '{16, 40, 24, 110};
   int hs[4] = '{96, 128, 136, 40};
   int hb[4] = '{48, 88, 160, 220};
   int vv[4] = '{480, 600, 768, 720};
   int vf[4] = '{10, 1, 3, 5};
   int vs[4] = '{2, 4, 6, 5};
   int vb[4] = '{33, 23, 29, 20};

   // {mode, h_pol, v_pol, 8 x 12-bit parameters}; odd modes are positive sync
   function automatic logic [99:0] cfg_of(input int m);
      logic pol;
      pol = (m % 2) == 1;
      return {2'(m), pol, pol,
              12'(hv[m]), 12'(hf[m]), 12'(hs[m]), 12'(hb[m]),
              12'(vv[m]), 12'(vf[m]), 12'(vs[m]), 12'(vb[m])};
   endfunction

   logic [99:0] act_cfg;
   assign act_cfg = {cur_mode, h_pol, v_pol, h_visible, h_front, h_sync, h_back,
                     v_visible, v_front, v_sync, v_back};

   // ---------------- scoreboard ----------------
   logic [EXP_W-1:0] exp_q[$];
   int checks = 0;
   int errors = 0;
   int model_mode;

   task automatic check(input string name, input logic [EXP_W-1:0] act, input logic [EXP_W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: every mode_changed pulse must match the oldest expected release
   always @(negedge clk) begin : monitor
      logic [EXP_W-1:0] e;
      if (mode_changed === 1'b1) begin
         if (exp_q.size() == 0) begin
            check("unexpected_mode_changed", 1, 0);
         end else begin
            e = exp_q.pop_front();
            check("mode_changed_event", {32'(cyc), act_cfg}, e);
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Called at a negedge; returns at the negedge of the first cycle with timers released
   task automatic wait_release(input int exp_cyc);
      int n;
      n = 0;
      while (timers_rstn !== 1'b1 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 2000) check("release_timeout", 0, 1);
      else           check("release_cycle", cyc, exp_cyc);
   endtask

   task automatic do_reset();
      int r;
      step();
      rstn = 1'b0;
      repeat (3) step();
      @(negedge clk);
      check("reset_cfg", act_cfg, cfg_of(0));
      check("reset_status", {timers_rstn, req_if.req_ready, busy, mode_changed}, 4'b0010);
      step();
      rstn = 1'b1;
      r = cyc;
      @(negedge clk);
      model_mode = 0;
      wait_release(r + SETTLE);
   endtask

   // Issue one request; returns the acceptance cycle, ends at negedge of cycle acc+1
   task automatic issue(input int m, input bit with_fe, output int acc);
      step();
      req_if.req_valid = 1'b1;
      req_if.req_mode  = 2'(m);
      frame_end        = with_fe;
      @(negedge clk);
      check("req_ready_in_run", req_if.req_ready, 1);
      acc = cyc;
      step();
      req_if.req_valid = 1'b0;
      frame_end        = 1'b0;
      @(negedge clk);
   endtask

   // Full change sequence with optional coincident frame_end and lock drop
   task automatic do_change(input int m, input int delay, input bit coinc,
                            input bit drop, input int drop_at, input int drop_len);
      int acc, f, e, rel;
      issue(m, coinc, acc);
      if (m == model_mode) begin
         check("same_mode_status", {busy, req_if.req_ready, timers_rstn}, 3'b011);
         check("same_mode_cfg", act_cfg, cfg_of(model_mode));
         return;
      end
      check("accept_status", {busy, req_if.req_ready, timers_rstn}, 3'b101);
      check("accept_cfg_unchanged", act_cfg, cfg_of(model_mode));
      repeat (delay) step();
      step();
      frame_end = 1'b1;
      f = cyc;
      @(negedge clk);
      check("frame_end_cycle_cfg", act_cfg, cfg_of(model_mode));
      step();
      frame_end = 1'b0;
      @(negedge clk);
      e = cyc;
      check("switch_cycle", e, f + 1);
      check("switch_cfg", act_cfg, cfg_of(m));
      check("switch_status", {timers_rstn, busy}, 2'b01);
      rel = drop ? (e + drop_at + drop_len + SETTLE) : (e + SETTLE);
      exp_q.push_back({32'(rel), cfg_of(m)});
      if (drop) begin
         repeat (drop_at) step();
         pll_locked = 1'b0;
         repeat (drop_len) step();
         pll_locked = 1'b1;
         @(negedge clk);
      end
      wait_release(rel);
      model_mode = m;
   endtask

   // frame_end while running must be ignored
   task automatic stray_frame_end();
      step();
      frame_end = 1'b1;
      step();
      frame_end = 1'b0;
      @(negedge clk);
      check("stray_frame_end", {busy, act_cfg}, {1'b0, cfg_of(model_mode)});
   endtask

   // Change request that never sees a frame_end
   task automatic no_frame_end_case(input int m);
      int acc, e;
      issue(m, 1'b0, acc);
`ifdef VGA_MODE_CTRL_TIMEOUT_EN
      while (cyc < acc + TMO) step();
      @(negedge clk);
      check("timeout_before_cfg", act_cfg, cfg_of(model_mode));
      step();
      @(negedge clk);
      e = cyc;
      check("timeout_cfg", act_cfg, cfg_of(m));
      check("timeout_status", timers_rstn, 0);
      exp_q.push_back({32'(e + SETTLE), cfg_of(m)});
      wait_release(e + SETTLE);
      model_mode = m;
`else
      repeat (200) step();
      @(negedge clk);
      check("stuck_in_wait", {busy, req_if.req_ready, timers_rstn, act_cfg},
            {3'b101, cfg_of(model_mode)});
      step();
      frame_end = 1'b1;
      step();
      frame_end = 1'b0;
      @(negedge clk);
      e = cyc;
      check("late_switch_cfg", act_cfg, cfg_of(m));
      exp_q.push_back({32'(e + SETTLE), cfg_of(m)});
      wait_release(e + SETTLE);
      model_mode = m;
`endif
   endtask

   // ---------------- stimulus ----------------
   initial begin : stim
      int acc, m;
      rstn             = 1'b0;
      pll_locked       = 1'b1;
      frame_end        = 1'b0;
      req_if.req_valid = 1'b0;
      req_if.req_mode  = 2'd0;
      model_mode       = 0;

      do_reset();
      do_change(3, MAX_DELAY, 1'b0, 1'b0, 0, 0);   // switch to mode 3
      do_change(3, 0, 1'b0, 1'b0, 0, 0);           // same-mode request
      stray_frame_end();
      do_change(1, 5, 1'b0, 1'b1, 10, 5);          // lock drop inside HOLD
      do_change(2, 7, 1'b1, 1'b0, 0, 0);           // accept coincident with frame_end

      for (int i = 0; i < 14; i++) begin
         repeat ($urandom_range(0, 5)) step();
         if ($urandom_range(0, 2) == 0) stray_frame_end();
         do_change(int'($urandom_range(0, 3)), int'($urandom_range(0, MAX_DELAY)),
                   $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0,
                   int'($urandom_range(1, SETTLE - 1)), int'($urandom_range(1, 8)));
      end

      no_frame_end_case((model_mode + 1) % 4);

      // Reset while a change is pending discards it
      m = (model_mode == 0) ? 2 : 0;
      if (m == 0) do_change(1, 3, 1'b0, 1'b0, 0, 0);
      issue(2 + (model_mode == 2 ? 1 : 0), 1'b0, acc);
      do_reset();
      stray_frame_end();
      check("after_reset_mode", cur_mode, 0);

      repeat (4) step();
      check("events_drained", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Hard stop if something hangs
   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1);
   end
endmodule

// File: doc/vga_mode_ctrl.md
# vga_mode_ctrl

Runtime video-mode controller for the VGA timing chain. It holds a preset table of four display modes and drives the visible/porch/sync/polarity configuration of the horizontal and vertical line timers. Mode-change requests arrive over a valid/ready handshake and are applied only at a frame boundary. During a change the block holds the timers in reset until the pixel-clock PLL reports lock and a settle interval has elapsed. It sits between the system control logic, the timers and the pixel-clock generator.

## Interface
- LINE_WIDTH, 12, width of every timing parameter output; must be ≥ 11
- SETTLE_CYCLES, 16, minimum cycles the timers are held in reset per (re)configuration; must be ≥ 1
- DEFAULT_MODE, 0, mode loaded at reset; 0..3
- TIMEOUT_CYCLES, 2**20, frame_end wait limit (used only with VGA_MODE_CTRL_TIMEOUT_EN)

Ports:
- clk  in  1  clock
- rstn  in  1  reset; synchronous, active-low
- req_valid  in  1  mode-change request valid
- req_mode  in  2  requested mode id
- req_ready  out  1  request accepted when req_valid && req_ready
- pll_locked  in  1  pixel-clock PLL lock; level
- frame_end  in  1  one-cycle pulse on the last pixel of a frame, from the vertical timer
- timers_rstn  out  1  active-low synchronous reset for the h/v timers
- h_visible, h_front, h_sync, h_back  out  LINE_WIDTH  horizontal timing
- v_visible, v_front, v_sync, v_back  out  LINE_WIDTH  vertical timing
- h_pol, v_pol  out  1  sync polarity; 1 = active high
- cur_mode  out  2  mode currently driven; also selects the PLL configuration
- busy  out  1  high in every state except RUN
- mode_changed  out  1  one-cycle pulse when the timers are released after a change

## Operation
- Preset table (visible/front/sync/back, polarity):
  - mode 0: 640/16/96/48 and 480/10/2/33, neg/neg
  - mode 1: 800/40/128/88 and 600/1/4/23, pos/pos
  - mode 2: 1024/24/136/160 and 768/3/6/29, neg/neg
  - mode 3: 1280/110/40/220 and 720/5/5/20, pos/pos
- All parameter outputs are registered and zero-extended to LINE_WIDTH. They change only on entry to HOLD.
- FSM states: HOLD, RUN, WAIT_FRAME.
  - HOLD: timers_rstn=0, req_ready=0. settle_cnt counts up while pll_locked=1 and clears to 0 whenever pll_locked=0. Move to RUN when settle_cnt reaches SETTLE_CYCLES-1 with pll_locked=1.
  - RUN: timers_rstn=1, req_ready=1.
    - On accept with req_mode==cur_mode: the request is consumed, stay in RUN, no pulse.
    - On accept with any other mode: latch pend_mode, go to WAIT_FRAME.
  - WAIT_FRAME: req_ready=0, timers keep running on the old mode. On frame_end=1: load the pend_mode parameters, set cur_mode=pend_mode, go to HOLD.
- Exit from HOLD to RUN pulses mode_changed, except for the exit that follows reset.
- A frame_end pulse outside WAIT_FRAME is ignored.
- If frame_end arrives in the same cycle a request is accepted in RUN, the change waits for the next frame_end. A change is never applied on the acceptance cycle.

## Timing
- Reset values: FSM in HOLD, cur_mode=DEFAULT_MODE, all parameters loaded from DEFAULT_MODE, timers_rstn=0, req_ready=0, busy=1, mode_changed=0, settle_cnt=0.
- Reset applied mid-operation aborts any pending change; pend_mode is discarded.
- Accept in RUN at cycle N: busy=1 and req_ready=0 from N+1.
- frame_end at cycle F in WAIT_FRAME: new parameters, new cur_mode and timers_rstn=0 all visible at F+1.
- Minimum hold with pll_locked=1 throughout: timers_rstn=0 for exactly SETTLE_CYCLES cycles. timers_rstn=1 and mode_changed=1 are visible together in the first RUN cycle.
- A lock drop during HOLD restarts the full settle count.
- pll_locked is ignored outside HOLD.

## Configuration
- VGA_MODE_CTRL_TIMEOUT_EN defined: a wait counter runs in WAIT_FRAME. If no frame_end arrives within TIMEOUT_CYCLES cycles, the change is forced exactly as if frame_end had arrived on the timeout cycle.
- Not defined: WAIT_FRAME waits indefinitely for frame_end, and no counter logic is generated.

## Test plan
- Reset with DEFAULT_MODE=0, pll_locked=1 -> timers_rstn=0 for 16 cycles; params 640/16/96/48 and 480/10/2/33, h_pol=v_pol=0; no mode_changed pulse.
- In RUN, request mode 3, frame_end 100 cycles later -> req_ready=0 the next cycle; params unchanged until frame_end. At F+1: h 1280/110/40/220, cur_mode=3. mode_changed at F+17.
- Request mode == cur_mode -> accepted in one cycle; busy stays 0; no timers_rstn activity.
- pll_locked drops at cycle 10 of HOLD and returns 5 cycles later -> timers_rstn stays 0 for a further 16 cycles after lock returns.
- Accept coincident with frame_end -> no switch; the switch happens on the following frame_end.
- With VGA_MODE_CTRL_TIMEOUT_EN and TIMEOUT_CYCLES=64, no frame_end -> forced switch after 64 cycles in WAIT_FRAME; without the macro, the block remains in WAIT_FRAME.
